// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
// Receives PS/2 device-to-host frames on raw, asynchronous PS2Clk/PS2Data
// lines and turns them into key events for the scan-code-to-ASCII stage.
//   - 2-flop synchronisers on both lines, plus a persistence filter on the clock.
//   - 11-bit frame deserialiser: start(0), 8 data bits LSB-first, odd parity, stop(1).
//   - Inter-edge timeout that abandons a stalled frame.
//   - E0/F0 prefix folding into a single key event.
//
// Ports:
//   sys_clk       in   system clock
//   reset         in   synchronous, active-high reset
//   PS2Clk        in   raw PS/2 clock line (asynchronous)
//   PS2Data       in   raw PS/2 data line (asynchronous)
//   frame_valid   out  one-cycle pulse, good frame received
//   frame_byte    out  last good byte, held until the next good frame
//   frame_error   out  one-cycle pulse, parity/stop/timeout failure
//   key_valid     out  one-cycle pulse, complete key event
//   key_code      out  scan code of the event, held until the next key_valid
//   key_extended  out  event was preceded by E0
//   key_break     out  event was preceded by F0 (key release)
//   busy          out  a frame is in progress
//
// Handshake: there is no back-pressure. frame_valid/frame_error/key_valid are
// single-cycle strobes; the accompanying data outputs stay stable until the
// next strobe of the same kind, so a consumer may sample them at any time
// after the strobe.
module ps2_frame_rx #(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic       frame_valid,
  output logic [7:0] frame_byte,
  output logic       frame_error,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_break,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt_clk, filt_clk_d;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] to_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic          ext_pending, brk_pending;

  logic sample_evt, to_hit, frame_done, frame_ok, timeout;

  // Synchronisers idle high, matching the released state of the bus.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= PS2Clk;
      clk_s2  <= clk_s1;
      data_s1 <= PS2Data;
      data_s2 <= data_s1;
    end
  end

  // Persistence filter: the clock must disagree with the filtered value for
  // FILTER_CYCLES consecutive samples before the filtered value follows it.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      filt_clk_d <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_CYCLES - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign sample_evt = filt_clk_d & ~filt_clk;
  // A sample event clears the timer, so it always wins over a timeout.
  assign to_hit     = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge sys_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (sample_evt && !data_s2)            state_nxt = DATA;
      DATA:   if (sample_evt && bit_cnt == 3'd7)     state_nxt = PARITY;
      PARITY: if (sample_evt)                        state_nxt = STOP;
      STOP:   if (sample_evt)                        state_nxt = IDLE;
      default:                                       state_nxt = IDLE;
    endcase
    if (state != IDLE && !sample_evt && to_hit) state_nxt = IDLE;
  end

  // FSM-derived controls
  always_comb begin
    busy       = (state != IDLE);
    frame_done = (state == STOP) && sample_evt;
    frame_ok   = frame_done && (^shift ^ par_bit) && data_s2;
    timeout    = (state != IDLE) && !sample_evt && to_hit;
  end

  // Deserialiser datapath and inter-edge timer
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (state == IDLE || sample_evt || timeout) to_cnt <= '0;
      else                                        to_cnt <= to_cnt + TW'(1);

      if (sample_evt) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_bit <= data_s2;
          default: ;
        endcase
      end
    end
  end

  // Frame result strobes
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_byte  <= '0;
    end else begin
      frame_valid <= frame_ok;
      frame_error <= (frame_done && !frame_ok) || timeout;
      if (frame_ok) frame_byte <= shift;
    end
  end

  // Prefix folding: E0/F0 only arm flags; any other byte closes the event.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      ext_pending  <= 1'b0;
      brk_pending  <= 1'b0;
      key_valid    <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_break    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_error) begin
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (frame_valid) begin
        if (frame_byte == 8'hE0) begin
          ext_pending <= 1'b1;
        end else if (frame_byte == 8'hF0) begin
          brk_pending <= 1'b1;
        end else begin
          key_valid    <= 1'b1;
          key_code     <= frame_byte;
          key_extended <= ext_pending;
          key_break    <= brk_pending;
          ext_pending  <= 1'b0;
          brk_pending  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx. Timing is scaled down (short PS/2 half-period and
// timeout) so the whole run stays small; the relations between them match the
// real-rate case.
module tb_ps2_frame_rx;

  localparam int FILT = 8;
  localparam int TMO  = 400;
  localparam int HALF = 50;
  // Raw clock fall -> sample event: 2 sync + FILT filter flops; the error
  // strobe then lands TMO+1 cycles after the sample-event cycle.
  localparam int TMO_LAT = 2 + FILT + TMO + 1;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       PS2Clk  = 1'b1;
  logic       PS2Data = 1'b1;
  logic       frame_valid, frame_error, key_valid, key_extended, key_break, busy;
  logic [7:0] frame_byte, key_code;

  ps2_frame_rx #(.FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .PS2Clk       (PS2Clk),
    .PS2Data      (PS2Data),
    .frame_valid  (frame_valid),
    .frame_byte   (frame_byte),
    .frame_error  (frame_error),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_extended (key_extended),
    .key_break    (key_break),
    .busy         (busy)
  );

  // ---------------- clock / reset ----------------
  always #10 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc = cyc + 1;

  initial begin
    #10ms;
    $display("FAIL watchdog: got still running, need finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [8:0] frame_q[$];  // {is_error, byte}
  logic [9:0] key_q[$];    // {extended, break, code}
  bit         model_ext = 1'b0;
  bit         model_brk = 1'b0;
  logic       fv_d = 1'b0;

  always @(negedge sys_clk) begin
    logic [8:0] fe;
    logic [9:0] ke;
    if (!reset) begin
      if (frame_valid && frame_error) check("frame_both", 32'(frame_valid & frame_error), 0);
      if (frame_valid || frame_error) begin
        check("frame_expected", 32'(frame_q.size() > 0), 1);
        if (frame_q.size() > 0) begin
          fe = frame_q.pop_front();
          check("frame_error_bit", 32'(frame_error), 32'(fe[8]));
          if (!fe[8]) check("frame_byte", 32'(frame_byte), 32'(fe[7:0]));
        end
      end
      if (key_valid) begin
        check("key_after_frame", 32'(fv_d), 1);
        check("key_expected", 32'(key_q.size() > 0), 1);
        if (key_q.size() > 0) begin
          ke = key_q.pop_front();
          check("key_event", {22'd0, key_extended, key_break, key_code}, {22'd0, ke});
        end
      end
    end
    fv_d = frame_valid;
  end

  // ---------------- drivers ----------------
  int last_fall = 0;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      PS2Data = bits[i];
      wait_cycles(HALF);
      PS2Clk    = 1'b0;
      last_fall = cyc;
      wait_cycles(HALF);
      PS2Clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    if (bad_par) begin
      frame_q.push_back({1'b1, 8'h00});
      model_ext = 1'b0;
      model_brk = 1'b0;
    end else begin
      frame_q.push_back({1'b0, b});
      if (b == 8'hE0)      model_ext = 1'b1;
      else if (b == 8'hF0) model_brk = 1'b1;
      else begin
        key_q.push_back({model_ext, model_brk, b});
        model_ext = 1'b0;
        model_brk = 1'b0;
      end
    end
    send_bits(make_frame(b, bad_par), 11);
    wait_cycles(2 * HALF);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tmo_cyc;
    int busy_hits;

    reset = 1'b1;
    wait_cycles(5);
    check("rst_frame_valid", 32'(frame_valid), 0);
    check("rst_frame_error", 32'(frame_error), 0);
    check("rst_frame_byte",  32'(frame_byte), 0);
    check("rst_key_valid",   32'(key_valid), 0);
    check("rst_key",         {22'd0, key_extended, key_break, key_code}, 0);
    check("rst_busy",        32'(busy), 0);
    reset = 1'b0;
    wait_cycles(20);

    // Plain make code
    send_byte(8'h1C, 1'b0);
    // Break of 1C, then plain 1C
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    send_byte(8'h1C, 1'b0);
    // Extended break, with a repeated prefix in between
    send_byte(8'hE0, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    // Parity error clears a pending E0
    send_byte(8'hE0, 1'b0);
    send_byte(8'h1C, 1'b1);
    send_byte(8'h1C, 1'b0);
    // E1 and AA are ordinary bytes
    send_byte(8'hE1, 1'b0);
    send_byte(8'hAA, 1'b0);

    // Timeout: start + 3 data bits, then clock held high
    frame_q.push_back({1'b1, 8'h00});
    model_ext = 1'b0;
    model_brk = 1'b0;
    send_bits(make_frame(8'h1C, 1'b0), 4);
    check("tmo_busy_mid", 32'(busy), 1);
    tmo_cyc = -1;
    for (int i = 0; i < TMO + 200; i++) begin
      @(negedge sys_clk);
      if (frame_error) begin
        tmo_cyc = cyc;
        break;
      end
    end
    check("tmo_seen", 32'(tmo_cyc != -1), 1);
    if (tmo_cyc != -1) begin
      check("tmo_latency", 32'(tmo_cyc - last_fall), 32'(TMO_LAT));
      check("tmo_busy_drop", 32'(busy), 0);
    end
    wait_cycles(2 * HALF);
    send_byte(8'h1C, 1'b0);

    // Short glitch on the clock while idle
    PS2Clk = 1'b0;
    wait_cycles(3);
    PS2Clk = 1'b1;
    busy_hits = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (busy) busy_hits++;
    end
    check("glitch_busy", 32'(busy_hits), 0);

    // Reset in the middle of a frame
    send_bits(make_frame(8'h5A, 1'b0), 3);
    wait_cycles(5);
    check("abort_busy_before", 32'(busy), 1);
    reset = 1'b1;
    @(negedge sys_clk);
    check("abort_busy_after", 32'(busy), 0);
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(2 * HALF);
    send_byte(8'h1C, 1'b0);

    wait_cycles(50);
    check("frame_q_drained", 32'(frame_q.size()), 0);
    check("key_q_drained",   32'(key_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
